jk_counter_bank: RTL and testbench
==================================

Name: jk_counter_bank

Overview:
- Parametrised successor to the single JK flip-flop: a WIDTH-bit bank of JK cells sharing one clock.
- Two operating styles:
  - Per-bit JK control (hold/set/reset/toggle) with active-low J/K inputs.
  - Cascadable modulo-MODULUS up/down counter with carry-in/carry-out.
- Serves as the digit register for the stopwatch (e.g. WIDTH=4, MODULUS=10 for seconds digits; MODULUS=6 for tens).

Parameters:
- WIDTH, 4, number of bits (1..16).
- MODULUS, 10, count modulus in counter modes (2..2^WIDTH).

Ports:
- CP  in  1  clock, rising-edge active.
- RST  in  1  synchronous reset, active-high.
- CE  in  1  clock enable; 0 freezes all state.
- MODE  in  2  00 hold, 01 JK, 10 count up, 11 count down.
- INVJ  in  WIDTH  per-bit J, active-low (used in MODE 01 only).
- INVK  in  WIDTH  per-bit K, active-low (used in MODE 01 only).
- CI  in  1  count enable / carry-in from the lower digit (counter modes only).
- Q  out  WIDTH  register value.
- INVQ  out  WIDTH  always equal to ~Q.
- CO  out  1  carry/borrow out to the next digit, combinational.
- WRAP  out  1  registered one-cycle pulse: a wrap occurred on the previous edge.

Behaviour:
- Reset: when RST=1 at a CP edge, Q=0, INVQ=all ones, WRAP=0.
  - RST overrides CE, MODE and all other inputs.
  - Reset in the middle of a count sequence discards the count; counting resumes from 0 on the first non-reset enabled edge.
- CE=0: Q and INVQ hold; WRAP is cleared to 0 on that edge; CO is forced to 0.
- MODE 00: Q holds; WRAP is 0 on the next edge.
- MODE 01, per bit i, with j=~INVJ[i] and k=~INVK[i]:
  - j=0, k=0: hold.
  - j=1, k=0: set to 1.
  - j=0, k=1: reset to 0.
  - j=1, k=1: toggle.
  - Bits are independent. Q may be loaded to any value, including values >= MODULUS. WRAP=0.
- MODE 10, count up:
  - CI=1 and Q < MODULUS-1: Q <= Q+1.
  - CI=1 and Q >= MODULUS-1: Q <= 0 and WRAP <= 1. This covers out-of-range values loaded via JK, which wrap to 0 in one step.
  - CI=0: Q holds.
- MODE 11, count down:
  - CI=1 and 0 < Q <= MODULUS-1: Q <= Q-1.
  - CI=1 and (Q == 0 or Q >= MODULUS): Q <= MODULUS-1 and WRAP <= 1.
  - CI=0: Q holds.
- CO = CE & CI & MODE[1] & terminal.
  - terminal is Q >= MODULUS-1 in up mode and (Q == 0 or Q >= MODULUS) in down mode.
  - CO is asserted in the same cycle as the edge that will wrap, so the next digit steps on that same edge. Latency is zero cycles of CO relative to the wrap edge.
- WRAP: 1 for exactly the one cycle following a wrapping edge; 0 otherwise.
- Arithmetic: unsigned, WIDTH bits. MODULUS-1 is compared at WIDTH+1 bits so that MODULUS=2^WIDTH is legal; in that case the counter is a plain binary wrap.
- INVQ is derived from Q, not separately registered state, so it can never disagree with ~Q.

Decomposition:
- Shared package jk_pkg:
  - Mode constants MODE_HOLD=2'b00, MODE_JK=2'b01, MODE_UP=2'b10, MODE_DN=2'b11.
  - A 2-bit jk_action typedef (HOLD/SET/RST/TGL) plus a function mapping active-low (INVJ, INVK) to jk_action.
- Sub-module jk_cell: one bit with synchronous reset, enable and a 2-bit action input.
  - The bank instantiates WIDTH cells.
  - In counter modes the next value is computed in the bank; each cell is then driven with SET or RST accordingly.

Test Plan (WIDTH=4, MODULUS=10):
- Reset: RST=1 for 2 edges with MODE=10, CI=1 -> Q=0, INVQ=4'hF, WRAP=0, CO=0. Then RST=0 and 3 enabled edges -> Q=3.
- JK mode: from Q=0, MODE=01:
  - INVJ=4'b0000, INVK=4'b1111 -> Q=4'hF.
  - Then INVJ=4'b1111, INVK=4'b1010 -> Q=4'b1010.
  - Then INVJ=INVK=4'b0000 -> Q=4'b0101.
  - Then all inputs 1 -> Q holds at 4'b0101.
- Up count: MODE=10, CI=1, 12 edges from 0 -> Q follows 1..9,0,1,2. CO=1 only while Q=9. WRAP=1 only in the cycle Q=0 after 9.
- Down count and out-of-range load:
  - MODE=11 from Q=0 -> next Q=9 with WRAP pulse; CO=1 while Q=0.
  - JK-load Q=4'd13, then MODE=11 -> Q=9. JK-load 13, then MODE=10 -> Q=0.
- CE/CI gating: MODE=10 at Q=9.
  - CI=0 -> Q holds at 9, CO=0.
  - CE=0, CI=1 -> Q holds, CO=0.
  - CE=1, CI=1 -> Q=0, WRAP=1.
- Mid-count reset: counting up at Q=7, assert RST for one edge together with CI=1 -> Q=0 and WRAP=0. The next edge gives Q=1.

Source files
------------

// File: rtl/jk_pkg.sv
// Shared definitions for the JK counter bank: operating modes and the
// per-cell JK action encoding.
package jk_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_JK   = 2'b01;
    localparam logic [1:0] MODE_UP   = 2'b10;
    localparam logic [1:0] MODE_DN   = 2'b11;

    typedef enum logic [1:0] {
        ACT_HOLD = 2'b00,
        ACT_SET  = 2'b01,
        ACT_RST  = 2'b10,
        ACT_TGL  = 2'b11
    } jk_action_t;

    // Map active-low J/K inputs to the action a cell performs on the next edge.
    function automatic jk_action_t jk_decode(input logic invj, input logic invk);
        jk_action_t act;
        unique case ({invj, invk})
            2'b11:   act = ACT_HOLD;  // j=0, k=0
            2'b01:   act = ACT_SET;   // j=1, k=0
            2'b10:   act = ACT_RST;   // j=0, k=1
            default: act = ACT_TGL;   // j=1, k=1
        endcase
        return act;
    endfunction

endpackage

// File: rtl/jk_cell.sv
// One JK storage bit with synchronous reset, clock enable and an encoded
// action input.
module jk_cell
    import jk_pkg::*;
(
    input  logic       cp,
    input  logic       rst,
    input  logic       ce,
    input  jk_action_t act,
    output logic       q
);

    // Reset wins over enable; otherwise apply the requested JK action.
    always_ff @(posedge cp) begin
        // NOTE: registered state is always written with <=; a blocking = here
        // would let readers in other always_ff blocks see the new value early.
        if (rst) begin
            q <= 1'b0;
        end else if (ce) begin
            unique case (act)
                ACT_SET:  q <= 1'b1;
                ACT_RST:  q <= 1'b0;
                ACT_TGL:  q <= ~q;
                default:  q <= q;
            endcase
        end
    end

endmodule

// File: rtl/jk_counter_bank.sv
// WIDTH-bit bank of JK cells usable either as independent JK flip-flops or
// as a cascadable modulo-MODULUS up/down counter digit.
module jk_counter_bank
    import jk_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             CP,
    input  logic             RST,
    input  logic             CE,
    input  logic [1:0]       MODE,
    input  logic [WIDTH-1:0] INVJ,
    input  logic [WIDTH-1:0] INVK,
    input  logic             CI,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] INVQ,
    output logic             CO,
    output logic             WRAP
);

    // Limits held at WIDTH+1 bits so MODULUS = 2^WIDTH stays representable.
    localparam logic [WIDTH:0] MOD_M1  = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH:0] MOD_LIM = (WIDTH+1)'(MODULUS);

    logic [WIDTH-1:0] q_int;
    logic [WIDTH-1:0] count_val;
    logic             up_term;
    logic             dn_term;
    logic             wrap_evt;
    jk_action_t       act [WIDTH];

    // Terminal detection; out-of-range values count as terminal in both directions.
    always_comb begin
        up_term = ({1'b0, q_int} >= MOD_M1);
        dn_term = (q_int == '0) || ({1'b0, q_int} >= MOD_LIM);
    end

    // Next counter value and per-cell actions for the selected mode.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned, which would infer a latch.
        count_val = q_int;
        wrap_evt  = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            act[i] = ACT_HOLD;
        end

        unique case (MODE)
            MODE_UP: if (CI) begin
                count_val = up_term ? '0 : q_int + 1'b1;
                wrap_evt  = up_term;
            end
            MODE_DN: if (CI) begin
                count_val = dn_term ? MOD_M1[WIDTH-1:0] : q_int - 1'b1;
                wrap_evt  = dn_term;
            end
            default: ;
        endcase

        for (int i = 0; i < WIDTH; i++) begin
            if (MODE == MODE_JK) begin
                act[i] = jk_decode(INVJ[i], INVK[i]);
            end else if (MODE[1] && CI) begin
                act[i] = count_val[i] ? ACT_SET : ACT_RST;
            end
        end
    end

    // The storage itself: one JK cell per bit, all sharing reset and enable.
    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        jk_cell u_cell (
            .cp  (CP),
            .rst (RST),
            .ce  (CE),
            .act (act[g]),
            .q   (q_int[g])
        );
    end

    // One-cycle pulse after any edge on which the counter wrapped.
    always_ff @(posedge CP) begin
        if (RST) begin
            WRAP <= 1'b0;
        end else begin
            WRAP <= CE & wrap_evt;
        end
    end

    // Carry out is combinational so the next digit steps on the same edge.
    always_comb begin
        Q    = q_int;
        INVQ = ~q_int;
        CO   = CE & CI & MODE[1] & (MODE[0] ? dn_term : up_term);
    end

endmodule

// File: tb/tb_jk_counter_bank.sv
// Self-checking bench for jk_counter_bank (WIDTH=4, MODULUS=10): directed
// scenarios followed by random stimulus, all against a behavioural model.
module tb_jk_counter_bank;

    localparam int W = 4;
    localparam int M = 10;
    localparam int MASK = (1 << W) - 1;

    logic         CP = 1'b0;
    logic         RST, CE, CI;
    logic [1:0]   MODE;
    logic [W-1:0] INVJ, INVK, Q, INVQ;
    logic         CO, WRAP;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: register value, wrap flag, and whether Q is defined yet.
    int mq    = 0;
    bit mwrap = 1'b0;
    bit mknown = 1'b0;

    jk_counter_bank #(.WIDTH(W), .MODULUS(M)) dut (
        .CP   (CP),
        .RST  (RST),
        .CE   (CE),
        .MODE (MODE),
        .INVJ (INVJ),
        .INVK (INVK),
        .CI   (CI),
        .Q    (Q),
        .INVQ (INVQ),
        .CO   (CO),
        .WRAP (WRAP)
    );

    always #5 CP = ~CP;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, check CO before the edge, advance the model
    // across the edge, then check the registered outputs.
    task automatic step(input logic rst, input logic ce, input logic [1:0] mode,
                        input logic [W-1:0] invj, input logic [W-1:0] invk,
                        input logic ci);
        bit term;
        bit co_exp;
        int j, k;
        RST = rst; CE = ce; MODE = mode; INVJ = invj; INVK = invk; CI = ci;
        #1;
        if (mknown) begin
            term   = mode[0] ? (mq == 0 || mq >= M) : (mq >= M - 1);
            co_exp = ce && ci && mode[1] && term;
            chk("co", {3'b000, CO}, {3'b000, co_exp});
        end
        @(posedge CP);
        mwrap = 1'b0;
        if (rst) begin
            mq = 0;
            mknown = 1'b1;
        end else if (ce) begin
            case (mode)
                2'b01: begin
                    j  = ~int'(invj) & MASK;
                    k  = ~int'(invk) & MASK;
                    mq = ((j & ~mq) | (~k & mq)) & MASK;
                end
                2'b10: if (ci) begin
                    if (mq >= M - 1) begin mq = 0; mwrap = 1'b1; end
                    else mq = mq + 1;
                end
                2'b11: if (ci) begin
                    if (mq == 0 || mq >= M) begin mq = M - 1; mwrap = 1'b1; end
                    else mq = mq - 1;
                end
                default: ;
            endcase
        end
        #1;
        chk("q", Q, W'(mq));
        chk("invq", INVQ, W'(~mq & MASK));
        chk("wrap", {3'b000, WRAP}, {3'b000, mwrap});
    endtask

    // Load an arbitrary value through JK mode: j = target bits, k = the rest.
    task automatic jk_load(input logic [W-1:0] v);
        step(1'b0, 1'b1, 2'b01, ~v, v, 1'b0);
    endtask

    initial begin
        RST = 1'b0; CE = 1'b1; CI = 1'b0; MODE = 2'b00; INVJ = '1; INVK = '1;

        // Reset overrides counting, then counting starts from zero.
        step(1'b1, 1'b1, 2'b10, 4'hF, 4'hF, 1'b1);
        step(1'b1, 1'b1, 2'b10, 4'hF, 4'hF, 1'b1);
        chk("reset_q", Q, 4'h0);
        chk("reset_invq", INVQ, 4'hF);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 2'b10, 4'hF, 4'hF, 1'b1);
        chk("after_reset_count", Q, 4'd3);

        // JK mode: set all, reset selected, toggle, hold.
        step(1'b1, 1'b1, 2'b00, 4'hF, 4'hF, 1'b0);
        step(1'b0, 1'b1, 2'b01, 4'b0000, 4'b1111, 1'b0);
        chk("jk_set", Q, 4'hF);
        step(1'b0, 1'b1, 2'b01, 4'b1111, 4'b1010, 1'b0);
        chk("jk_reset", Q, 4'b1010);
        step(1'b0, 1'b1, 2'b01, 4'b0000, 4'b0000, 1'b0);
        chk("jk_toggle", Q, 4'b0101);
        step(1'b0, 1'b1, 2'b01, 4'b1111, 4'b1111, 1'b1);
        chk("jk_hold", Q, 4'b0101);

        // Up count through a wrap.
        step(1'b1, 1'b1, 2'b00, 4'hF, 4'hF, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 2'b10, 4'hF, 4'hF, 1'b1);
        chk("up_end", Q, 4'd2);

        // Down count from zero, and out-of-range loads in both directions.
        step(1'b1, 1'b1, 2'b00, 4'hF, 4'hF, 1'b0);
        step(1'b0, 1'b1, 2'b11, 4'hF, 4'hF, 1'b1);
        chk("down_wrap_q", Q, 4'd9);
        chk("down_wrap_pulse", {3'b000, WRAP}, 4'd1);
        jk_load(4'd13);
        step(1'b0, 1'b1, 2'b11, 4'hF, 4'hF, 1'b1);
        chk("oor_down", Q, 4'd9);
        jk_load(4'd13);
        step(1'b0, 1'b1, 2'b10, 4'hF, 4'hF, 1'b1);
        chk("oor_up", Q, 4'd0);

        // CE / CI gating at the terminal value.
        jk_load(4'd9);
        step(1'b0, 1'b1, 2'b10, 4'hF, 4'hF, 1'b0);
        step(1'b0, 1'b0, 2'b10, 4'hF, 4'hF, 1'b1);
        chk("gated_hold", Q, 4'd9);
        step(1'b0, 1'b1, 2'b10, 4'hF, 4'hF, 1'b1);
        chk("gated_release", Q, 4'd0);

        // Reset in the middle of a count discards it.
        jk_load(4'd7);
        step(1'b1, 1'b1, 2'b10, 4'hF, 4'hF, 1'b1);
        step(1'b0, 1'b1, 2'b10, 4'hF, 4'hF, 1'b1);
        chk("mid_reset_resume", Q, 4'd1);

        // Random stimulus against the model.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 7) != 0),
                 2'($urandom_range(0, 3)),
                 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
